// File: rtl/vga_pkg.sv
// Shared defaults, coordinate type and small helpers for the VGA scan path.
// The defaults describe the 1280x800@60 panel timing.
package vga_pkg;

  localparam int DEF_COOR_WIDTH = 12;
  localparam int DEF_HSIZE      = 1280;
  localparam int DEF_HFP        = 1344;
  localparam int DEF_HSP        = 1480;
  localparam int DEF_HMAX       = 1680;
  localparam int DEF_VSIZE      = 800;
  localparam int DEF_VFP        = 801;
  localparam int DEF_VSP        = 804;
  localparam int DEF_VMAX       = 828;

  typedef logic [DEF_COOR_WIDTH-1:0] coord_t;

  typedef enum logic [1:0] {
    FADE_HOLD,
    FADE_UP,
    FADE_DOWN
  } fade_dir_e;

  // Words per framebuffer part.
  function automatic int ram_size(int left, int right, int top, int bottom);
    return (right - left) * (bottom - top);
  endfunction

  // Half-open interval test: lo <= v < hi.
  function automatic logic in_range(int v, int lo, int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_fade_ctrl.sv
// Night-rate fade engine: every FADE_FRAMES enabled swaps, move night_rate one
// step toward night_target, which is sampled only on that stepping edge.
module vga_fade_ctrl
  import vga_pkg::*;
#(
  parameter int NIGHT_RATE_WIDTH = 6,
  parameter int FADE_FRAMES      = 4
) (
  input  logic                        clk_vga,
  input  logic                        rst,
  input  logic                        step_en,
  input  logic [NIGHT_RATE_WIDTH-1:0] night_target,
  output logic [NIGHT_RATE_WIDTH-1:0] night_rate
);

  localparam int DIV_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  fade_dir_e        dir;

  assign div_wrap = (div_cnt == DIV_W'(FADE_FRAMES - 1));

  always_comb begin
    // NOTE: default first so every path assigns dir and no latch is inferred.
    dir = FADE_HOLD;
    if (night_rate < night_target)      dir = FADE_UP;
    else if (night_rate > night_target) dir = FADE_DOWN;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      div_cnt    <= '0;
      night_rate <= '0;
    end else if (step_en) begin
      if (div_wrap) begin
        div_cnt <= '0;
        case (dir)
          FADE_UP:   night_rate <= night_rate + 1'b1;
          FADE_DOWN: night_rate <= night_rate - 1'b1;
          default:   ;
        endcase
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: coordinate counters, framebuffer read addressing with
// double-buffer swap, delayed panel strobes and the night-rate fade engine.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int COOR_WIDTH       = DEF_COOR_WIDTH,
  parameter int HSIZE            = DEF_HSIZE,
  parameter int HFP              = DEF_HFP,
  parameter int HSP              = DEF_HSP,
  parameter int HMAX             = DEF_HMAX,
  parameter int VSIZE            = DEF_VSIZE,
  parameter int VFP              = DEF_VFP,
  parameter int VSP              = DEF_VSP,
  parameter int VMAX             = DEF_VMAX,
  parameter bit HSPP             = 1'b1,
  parameter bit VSPP             = 1'b1,
  parameter int FRAME_LEFT       = 0,
  parameter int FRAME_RIGHT      = 1280,
  parameter int FRAME_TOP        = 250,
  parameter int FRAME_BOTTOM     = 550,
  parameter int RAM_WIDTH        = 20,
  parameter int PIPE_DELAY       = 4,
  parameter int SWAP_X           = 8,
  parameter int FRAME_CNT_WIDTH  = 8,
  parameter int NIGHT_RATE_WIDTH = 6,
  parameter int FADE_FRAMES      = 4
) (
  input  logic                        clk_vga,
  input  logic                        rst,
  input  logic [NIGHT_RATE_WIDTH-1:0] night_target,
  output logic [COOR_WIDTH-1:0]       read_x,
  output logic [COOR_WIDTH-1:0]       read_y,
  output logic                        read_enable,
  output logic [RAM_WIDTH-1:0]        read_addr,
  output logic                        read_part,
  output logic                        swap_pulse,
  output logic [FRAME_CNT_WIDTH-1:0]  frame_count,
  output logic [NIGHT_RATE_WIDTH-1:0] night_rate,
  output logic [COOR_WIDTH-1:0]       out_x,
  output logic [COOR_WIDTH-1:0]       out_y,
  output logic                        out_in_frame,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        data_enable
);

  localparam int RAM_SIZE = ram_size(FRAME_LEFT, FRAME_RIGHT, FRAME_TOP, FRAME_BOTTOM);
  localparam int STAGES   = PIPE_DELAY - 1;

  logic [RAM_WIDTH-1:0]  addr_cnt;
  logic                  swap_hit;
  logic [COOR_WIDTH-1:0] pipe_x [STAGES];
  logic [COOR_WIDTH-1:0] pipe_y [STAGES];
  logic                  pipe_v [STAGES];
  logic                  out_valid;

  always_ff @(posedge clk_vga) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      read_x <= '0;
      read_y <= '0;
    end else if (read_x == COOR_WIDTH'(HMAX - 1)) begin
      read_x <= '0;
      read_y <= (read_y == COOR_WIDTH'(VMAX - 1)) ? '0 : read_y + 1'b1;
    end else begin
      read_x <= read_x + 1'b1;
    end
  end

  assign swap_hit    = (read_x == COOR_WIDTH'(SWAP_X)) && (read_y == COOR_WIDTH'(VSIZE));
  assign read_enable = in_range(int'(read_x), FRAME_LEFT, FRAME_RIGHT) &&
                       in_range(int'(read_y), FRAME_TOP, FRAME_BOTTOM);
  assign read_addr   = addr_cnt;

  // The swap row lies below the window, so the part reload never races an increment.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      addr_cnt    <= '0;
      read_part   <= 1'b0;
      swap_pulse  <= 1'b0;
      frame_count <= '0;
    end else begin
      swap_pulse <= swap_hit;
      if (swap_hit) begin
        read_part   <= ~read_part;
        frame_count <= frame_count + 1'b1;
        addr_cnt    <= read_part ? '0 : RAM_WIDTH'(RAM_SIZE);
      end else if (read_enable) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    // NOTE: the delay line is reset (not left as RAM-like storage) because its
    // valid bits gate the strobes during the first PIPE_DELAY cycles.
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
        pipe_v[i] <= 1'b0;
      end
    end else begin
      pipe_x[0] <= read_x;
      pipe_y[0] <= read_y;
      pipe_v[0] <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  assign out_x        = pipe_x[STAGES-1];
  assign out_y        = pipe_y[STAGES-1];
  assign out_valid    = pipe_v[STAGES-1];
  assign out_in_frame = out_valid &&
                        in_range(int'(out_x), FRAME_LEFT, FRAME_RIGHT) &&
                        in_range(int'(out_y), FRAME_TOP, FRAME_BOTTOM);

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hsync       <= ~HSPP;
      vsync       <= ~VSPP;
      data_enable <= 1'b0;
    end else begin
      hsync       <= (out_valid && in_range(int'(out_x), HFP, HSP)) ? HSPP : ~HSPP;
      vsync       <= (out_valid && in_range(int'(out_y), VFP, VSP)) ? VSPP : ~VSPP;
      data_enable <= out_valid && in_range(int'(out_x), 0, HSIZE) &&
                     in_range(int'(out_y), 0, VSIZE);
    end
  end

  vga_fade_ctrl #(
    .NIGHT_RATE_WIDTH (NIGHT_RATE_WIDTH),
    .FADE_FRAMES      (FADE_FRAMES)
  ) u_fade (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .step_en      (swap_hit),
    .night_target (night_target),
    .night_rate   (night_rate)
  );

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl on a miniature raster, with both sync
// polarities, against a cycle-count based reference model.
module tb_vga_scan_ctrl;

  localparam int CW = 12, RW = 20, FW = 8, NW = 6;
  localparam int HSIZE = 8, HFP = 10, HSP = 12, HMAX = 14;
  localparam int VSIZE = 4, VFP = 5, VSP = 6, VMAX = 7;
  localparam int FL = 2, FR = 6, FT = 1, FB = 3;
  localparam int PD = 3, SWAP_X = 1, FADE = 2;
  localparam int P = HMAX * VMAX;
  localparam int SWAP_IDX = VSIZE * HMAX + SWAP_X;
  localparam int WW = FR - FL, WH = FB - FT, RAM = WW * WH;
  localparam int VEC_W = 89;

  logic          clk_vga = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] night_target = '0;

  logic [CW-1:0] read_x, read_y, out_x, out_y;
  logic          read_enable, read_part, swap_pulse, out_in_frame, hsync, vsync, data_enable;
  logic [RW-1:0] read_addr;
  logic [FW-1:0] frame_count;
  logic [NW-1:0] night_rate;

  logic [CW-1:0] inv_read_x, inv_read_y, inv_out_x, inv_out_y;
  logic          inv_read_enable, inv_read_part, inv_swap_pulse, inv_out_in_frame;
  logic          inv_hsync, inv_vsync, inv_data_enable;
  logic [RW-1:0] inv_read_addr;
  logic [FW-1:0] inv_frame_count;
  logic [NW-1:0] inv_night_rate;

  logic [VEC_W-1:0] dut_vec, inv_vec;

  int tests = 0, failed = 0;
  int n = 0;         // edges since reset release
  int m_night = 0, m_div = 0;

  always #5 clk_vga = ~clk_vga;

  vga_scan_ctrl #(
    .COOR_WIDTH(CW), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(1'b1), .VSPP(1'b1),
    .FRAME_LEFT(FL), .FRAME_RIGHT(FR), .FRAME_TOP(FT), .FRAME_BOTTOM(FB),
    .RAM_WIDTH(RW), .PIPE_DELAY(PD), .SWAP_X(SWAP_X), .FRAME_CNT_WIDTH(FW),
    .NIGHT_RATE_WIDTH(NW), .FADE_FRAMES(FADE)
  ) u_dut (
    .clk_vga(clk_vga), .rst(rst), .night_target(night_target),
    .read_x(read_x), .read_y(read_y), .read_enable(read_enable), .read_addr(read_addr),
    .read_part(read_part), .swap_pulse(swap_pulse), .frame_count(frame_count),
    .night_rate(night_rate), .out_x(out_x), .out_y(out_y), .out_in_frame(out_in_frame),
    .hsync(hsync), .vsync(vsync), .data_enable(data_enable)
  );

  vga_scan_ctrl #(
    .COOR_WIDTH(CW), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(1'b0), .VSPP(1'b0),
    .FRAME_LEFT(FL), .FRAME_RIGHT(FR), .FRAME_TOP(FT), .FRAME_BOTTOM(FB),
    .RAM_WIDTH(RW), .PIPE_DELAY(PD), .SWAP_X(SWAP_X), .FRAME_CNT_WIDTH(FW),
    .NIGHT_RATE_WIDTH(NW), .FADE_FRAMES(FADE)
  ) u_dut_inv (
    .clk_vga(clk_vga), .rst(rst), .night_target(night_target),
    .read_x(inv_read_x), .read_y(inv_read_y), .read_enable(inv_read_enable),
    .read_addr(inv_read_addr), .read_part(inv_read_part), .swap_pulse(inv_swap_pulse),
    .frame_count(inv_frame_count), .night_rate(inv_night_rate), .out_x(inv_out_x),
    .out_y(inv_out_y), .out_in_frame(inv_out_in_frame), .hsync(inv_hsync),
    .vsync(inv_vsync), .data_enable(inv_data_enable)
  );

  assign dut_vec = {read_x, read_y, read_enable, read_addr, read_part, swap_pulse,
                    frame_count, night_rate, out_x, out_y, out_in_frame,
                    hsync, vsync, data_enable};
  assign inv_vec = {inv_read_x, inv_read_y, inv_read_enable, inv_read_addr, inv_read_part,
                    inv_swap_pulse, inv_frame_count, inv_night_rate, inv_out_x, inv_out_y,
                    inv_out_in_frame, inv_hsync, inv_vsync, inv_data_enable};

  // Reference model: everything derives from k, the read cycle index since reset.
  function automatic int cx(int k);
    return (k % P) % HMAX;
  endfunction

  function automatic int cy(int k);
    return (k % P) / HMAX;
  endfunction

  function automatic bit in_win(int x, int y);
    return x >= FL && x < FR && y >= FT && y < FB;
  endfunction

  function automatic int swaps(int k);
    return (k > SWAP_IDX) ? (k - 1 - SWAP_IDX) / P + 1 : 0;
  endfunction

  // Window pixels already read from the buffer part currently displayed.
  function automatic int win_done(int k);
    int x, y, rows, cols;
    x = cx(k);
    y = cy(k);
    if (k % P > SWAP_IDX) return 0;
    rows = (y < FT) ? 0 : (y >= FB) ? WH : y - FT;
    cols = (y >= FT && y < FB) ? ((x < FL) ? 0 : (x >= FR) ? WW : x - FL) : 0;
    return rows * WW + cols;
  endfunction

  function automatic int e_addr(int k);
    return (swaps(k) % 2) * RAM + win_done(k);
  endfunction

  function automatic logic [VEC_W-1:0] e_vec(int k, int night, bit pol);
    int ox, oy, sx, sy;
    bit ov, sv;
    ov = (k >= PD - 1);
    ox = ov ? cx(k - PD + 1) : 0;
    oy = ov ? cy(k - PD + 1) : 0;
    sv = (k >= PD);
    sx = sv ? cx(k - PD) : 0;
    sy = sv ? cy(k - PD) : 0;
    return {CW'(cx(k)), CW'(cy(k)), in_win(cx(k), cy(k)), RW'(e_addr(k)),
            1'(swaps(k) % 2), (k >= 1 && (k - 1) % P == SWAP_IDX), FW'(swaps(k)),
            NW'(night), CW'(ox), CW'(oy), ov && in_win(ox, oy),
            (sv && sx >= HFP && sx < HSP) ? pol : !pol,
            (sv && sy >= VFP && sy < VSP) ? pol : !pol,
            sv && sx < HSIZE && sy < VSIZE};
  endfunction

  // One clock edge: advance the model with the inputs the DUT sampled, then settle.
  task automatic tick();
    @(posedge clk_vga);
    if (rst) begin
      n = 0;
      m_div = 0;
      m_night = 0;
    end else begin
      if (n % P == SWAP_IDX) begin
        if (m_div == FADE - 1) begin
          m_div = 0;
          if (m_night < int'(night_target))      m_night++;
          else if (m_night > int'(night_target)) m_night--;
        end else begin
          m_div++;
        end
      end
      n++;
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    night_target = 6'd9;
    repeat (3) tick();
    tests++; if (read_x !== '0 || read_y !== '0) begin failed++; $display("FAIL reset_xy got %0d,%0d want 0,0", read_x, read_y); end
    tests++; if (read_addr !== '0) begin failed++; $display("FAIL reset_addr got %0d want 0", read_addr); end
    tests++; if (read_part !== 1'b0) begin failed++; $display("FAIL reset_part got %b want 0", read_part); end
    tests++; if (swap_pulse !== 1'b0) begin failed++; $display("FAIL reset_swap got %b want 0", swap_pulse); end
    tests++; if (frame_count !== '0) begin failed++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    tests++; if (night_rate !== '0) begin failed++; $display("FAIL reset_night got %0d want 0", night_rate); end
    tests++; if (hsync !== 1'b0 || vsync !== 1'b0) begin failed++; $display("FAIL reset_sync got %b%b want 00", hsync, vsync); end
    tests++; if (inv_hsync !== 1'b1 || inv_vsync !== 1'b1) begin failed++; $display("FAIL reset_sync_inv got %b%b want 11", inv_hsync, inv_vsync); end
    tests++; if (data_enable !== 1'b0) begin failed++; $display("FAIL reset_de got %b want 0", data_enable); end
    tests++; if (out_in_frame !== 1'b0) begin failed++; $display("FAIL reset_in_frame got %b want 0", out_in_frame); end
    tests++; if (out_x !== '0 || out_y !== '0) begin failed++; $display("FAIL reset_out_xy got %0d,%0d want 0,0", out_x, out_y); end
  endtask

  task automatic test_strobes();
    int first_de = -1, de_run = 0, sx, sy, ox, oy;
    bit sv, ov;
    logic e_hs, e_vs, e_de;
    night_target = '0;
    rst = 1'b0;
    for (int c = 0; c < 2 * P; c++) begin
      tick();
      sv = (n >= PD);
      sx = sv ? cx(n - PD) : 0;
      sy = sv ? cy(n - PD) : 0;
      e_hs = sv && sx >= HFP && sx < HSP;
      e_vs = sv && sy >= VFP && sy < VSP;
      e_de = sv && sx < HSIZE && sy < VSIZE;
      ov = (n >= PD - 1);
      ox = ov ? cx(n - PD + 1) : 0;
      oy = ov ? cy(n - PD + 1) : 0;
      tests++; if ({hsync, vsync, data_enable} !== {e_hs, e_vs, e_de}) begin failed++; $display("FAIL strobes n=%0d got %b%b%b want %b%b%b", n, hsync, vsync, data_enable, e_hs, e_vs, e_de); end
      tests++; if ({inv_hsync, inv_vsync, inv_data_enable} !== {~e_hs, ~e_vs, e_de}) begin failed++; $display("FAIL strobes_inv n=%0d got %b%b%b want %b%b%b", n, inv_hsync, inv_vsync, inv_data_enable, ~e_hs, ~e_vs, e_de); end
      tests++; if (out_x !== CW'(ox) || out_y !== CW'(oy) || out_in_frame !== (ov && in_win(ox, oy))) begin failed++; $display("FAIL out_coord n=%0d got %0d,%0d,%b want %0d,%0d,%b", n, out_x, out_y, out_in_frame, ox, oy, ov && in_win(ox, oy)); end
      if (data_enable === 1'b1) begin
        if (first_de < 0) first_de = n;
        if (n - first_de == de_run) de_run++;
      end
    end
    tests++; if (first_de != PD) begin failed++; $display("FAIL de_first got %0d want %0d", first_de, PD); end
    tests++; if (de_run != HSIZE) begin failed++; $display("FAIL de_run got %0d want %0d", de_run, HSIZE); end
  endtask

  task automatic test_address();
    pulse_reset();
    for (int c = 0; c < 2 * P + 1; c++) begin
      tick();
      tests++; if (read_x !== CW'(cx(n)) || read_y !== CW'(cy(n)) || read_enable !== in_win(cx(n), cy(n))) begin failed++; $display("FAIL raster n=%0d got %0d,%0d,%b want %0d,%0d,%b", n, read_x, read_y, read_enable, cx(n), cy(n), in_win(cx(n), cy(n))); end
      tests++; if (read_addr !== RW'(e_addr(n))) begin failed++; $display("FAIL addr n=%0d got %0d want %0d", n, read_addr, e_addr(n)); end
      tests++; if (read_part !== 1'(swaps(n) % 2) || frame_count !== FW'(swaps(n))) begin failed++; $display("FAIL part_count n=%0d got %b,%0d want %0d,%0d", n, read_part, frame_count, swaps(n) % 2, swaps(n)); end
      tests++; if (swap_pulse !== ((n - 1) % P == SWAP_IDX)) begin failed++; $display("FAIL swap_pulse n=%0d got %b", n, swap_pulse); end
      if (n == FT * HMAX + FL + 3) begin
        tests++; if (read_addr !== 20'd3) begin failed++; $display("FAIL addr_row1_end got %0d want 3", read_addr); end
      end
      if (n == 2 * HMAX + FL) begin
        tests++; if (read_addr !== 20'd4) begin failed++; $display("FAIL addr_row2_start got %0d want 4", read_addr); end
      end
      if (n == P + FT * HMAX + FL) begin
        tests++; if (read_addr !== 20'd8 || read_part !== 1'b1) begin failed++; $display("FAIL addr_part1_start got %0d,%b want 8,1", read_addr, read_part); end
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [FW-1:0] prev;
    bit wrap_seen = 0;
    pulse_reset();
    prev = frame_count;
    for (int c = 0; c < 257 * P; c++) begin
      tick();
      tests++; if (frame_count !== FW'(swaps(n)) || read_part !== 1'(swaps(n) % 2)) begin failed++; $display("FAIL frame_wrap n=%0d got %0d,%b want %0d,%0d", n, frame_count, read_part, swaps(n) % 256, swaps(n) % 2); end
      if (prev == 8'd255 && frame_count == 8'd0) wrap_seen = 1;
      prev = frame_count;
    end
    tests++; if (!wrap_seen) begin failed++; $display("FAIL frame_count_wrap got no 255->0 want wrap"); end
  endtask

  task automatic test_fade();
    pulse_reset();
    night_target = 6'd3;
    for (int c = 0; c < 7 * P; c++) begin
      tick();
      tests++; if (night_rate !== NW'(m_night)) begin failed++; $display("FAIL fade_up n=%0d got %0d want %0d", n, night_rate, m_night); end
      if ((n - 1) % P == SWAP_IDX && swaps(n) % 2 == 0) begin
        tests++; if (night_rate !== NW'(swaps(n) / 2)) begin failed++; $display("FAIL fade_step swap=%0d got %0d want %0d", swaps(n), night_rate, swaps(n) / 2); end
      end
    end
    tests++; if (night_rate !== 6'd3) begin failed++; $display("FAIL fade_hold got %0d want 3", night_rate); end
    night_target = 6'd1;
    for (int c = 0; c < 4 * P; c++) begin
      tick();
      tests++; if (night_rate !== NW'(m_night)) begin failed++; $display("FAIL fade_down n=%0d got %0d want %0d", n, night_rate, m_night); end
    end
    tests++; if (night_rate !== 6'd1) begin failed++; $display("FAIL fade_down_end got %0d want 1", night_rate); end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    night_target = 6'd5;
    repeat (3 * P + 2 * HMAX + 5) tick();
    tests++; if (read_x !== 12'd5 || read_y !== 12'd2 || read_part !== 1'b1 || night_rate !== 6'd1) begin failed++; $display("FAIL pre_reset got %0d,%0d,%b,%0d want 5,2,1,1", read_x, read_y, read_part, night_rate); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (read_x !== '0 || read_addr !== '0 || read_part !== 1'b0 || night_rate !== '0) begin failed++; $display("FAIL mid_reset got %0d,%0d,%b,%0d want 0,0,0,0", read_x, read_addr, read_part, night_rate); end
    tests++; if (data_enable !== 1'b0) begin failed++; $display("FAIL mid_reset_de0 got %b want 0", data_enable); end
    for (int c = 1; c <= PD; c++) begin
      tick();
      tests++; if (data_enable !== (c == PD)) begin failed++; $display("FAIL mid_reset_de n=%0d got %b want %b", n, data_enable, c == PD); end
    end
  endtask

  task automatic test_random();
    int len;
    logic [VEC_W-1:0] exp_main, exp_inv;
    for (int it = 0; it < 24; it++) begin
      night_target = NW'($urandom_range(0, 63));
      len = $urandom_range(1, 3 * P);
      rst = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < len; c++) begin
        tick();
        if (c == 0) rst = 1'b0;
        exp_main = e_vec(n, m_night, 1'b1);
        exp_inv  = e_vec(n, m_night, 1'b0);
        tests++; if (dut_vec !== exp_main) begin failed++; $display("FAIL random_main n=%0d got %h want %h", n, dut_vec, exp_main); end
        tests++; if (inv_vec !== exp_inv) begin failed++; $display("FAIL random_inv n=%0d got %h want %h", n, inv_vec, exp_inv); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_strobes();
    test_address();
    test_frame_wrap();
    test_fade();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Parametrised scan controller for the 1280x800 panel path: one pixel-clock domain that generates the raster, the delayed sync/enable strobes, the framebuffer read address with double-buffer part selection, and the frame-swap pulse. It also runs a per-frame night-rate fade engine that ramps the displayed night rate toward a target instead of jumping. It sits between the dual-port framebuffer RAM read port and the palette/output stage, and replaces hand-placed counter logic with one configurable block.

## Interface

- COOR_WIDTH, 12, coordinate counter width
- HSIZE / HFP / HSP / HMAX, 1280 / 1344 / 1480 / 1680, visible width, front-porch end, sync end, line total
- VSIZE / VFP / VSP / VMAX, 800 / 801 / 804 / 828, same for vertical
- HSPP / VSPP, 1 / 1, active sync polarity
- FRAME_LEFT / FRAME_RIGHT / FRAME_TOP / FRAME_BOTTOM, 0 / 1280 / 250 / 550, framebuffer window; FRAME_BOTTOM <= VSIZE
- RAM_WIDTH, 20, read address width
- PIPE_DELAY, 4, cycles from read coordinate to sync outputs; >= 2
- SWAP_X, 8, column on line VSIZE where the part swap fires; < HMAX
- FRAME_CNT_WIDTH, 8, frame counter width
- NIGHT_RATE_WIDTH, 6, night rate width
- FADE_FRAMES, 4, swaps per fade step; >= 1
- clk_vga  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- night_target  in  NIGHT_RATE_WIDTH  requested night rate
- read_x, read_y  out  COOR_WIDTH  stage-0 raster coordinate
- read_enable  out  1  stage-0 coordinate inside the frame window
- read_addr  out  RAM_WIDTH  framebuffer address for stage-0 coordinate
- read_part  out  1  buffer part being displayed
- swap_pulse  out  1  one-cycle frame-swap strobe
- frame_count  out  FRAME_CNT_WIDTH  swaps since reset, wrapping
- night_rate  out  NIGHT_RATE_WIDTH  current faded night rate
- out_x, out_y  out  COOR_WIDTH  coordinate delayed PIPE_DELAY-1 cycles
- out_in_frame  out  1  out_x/out_y inside the frame window and pipeline valid
- hsync, vsync, data_enable  out  1  registered panel strobes

## Operation

- Raster: read_x counts 0..HMAX-1; on wrap read_y increments, wrapping 0..VMAX-1.
- Delay line: PIPE_DELAY-1 registered stages carry (x, y, valid). valid enters as 1 after reset and is 0 in all stages at reset.
- Strobes, from the last delay stage, registered: hsync = HSPP iff valid and HFP<=x<HSP, else !HSPP; vsync likewise on y; data_enable = valid and x<HSIZE and y<VSIZE.
- Address: counter addr_cnt; read_addr = addr_cnt. Each cycle read_enable=1, addr_cnt+1. On a swap edge addr_cnt loads (new read_part)*RAM_SIZE, where RAM_SIZE = (FRAME_RIGHT-FRAME_LEFT)*(FRAME_BOTTOM-FRAME_TOP). This yields row-major addresses matching part*RAM_SIZE + (x-FRAME_LEFT) + (y-FRAME_TOP)*width.
- Swap: when stage-0 coordinate = (SWAP_X, VSIZE), on that edge: read_part toggles, swap_pulse<=1 for one cycle, frame_count+1 (wraps), fade divider advances.
- Fade: divider counts swaps 0..FADE_FRAMES-1. On the swap where it wraps, night_target is sampled and night_rate steps by 1 toward it; equal means hold. night_target is ignored between steps.

## Timing

- Reset values: read_x=read_y=0, addr_cnt=0, read_part=0, swap_pulse=0, frame_count=0, divider=0, night_rate=0, hsync=!HSPP, vsync=!VSPP, data_enable=0, out_in_frame=0, delay stages (0,0,invalid).
- Latency: the strobes at cycle t describe the read coordinate of cycle t-PIPE_DELAY. out_x/out_y lead the strobes by exactly 1 cycle, so the palette stage registers its colour alongside them.
- read_addr is valid in the same cycle as read_x/read_y; RAM read latency is absorbed by PIPE_DELAY.
- Mid-frame reset: all state returns to reset values on the next edge, and strobes stay inactive for the first PIPE_DELAY cycles.
- Swap and fade step coincide on one edge; night_rate changes only on swap edges.

## Structure

- Package vga_pkg: default timing localparams (1280x800@60), the RAM_SIZE function, and typedef coord_t sized by COOR_WIDTH.
- Sub-module vga_fade_ctrl: divider plus step toward target, driven by swap_pulse-equivalent enable.

## Test plan

Small timing for all cases: HSIZE=8, HFP=10, HSP=12, HMAX=14, VSIZE=4, VFP=5, VSP=6, VMAX=7, window x2..6 / y1..3, PIPE_DELAY=3, SWAP_X=1.

- Release rst -> data_enable first high 3 cycles later, for 8 cycles; hsync=HSPP while delayed x in 10..11; hsync/data_enable never asserted before valid propagates.
- Frame 0 -> read_addr 0..3 at y=1 x=2..5, then 4..7 at y=2. After the swap at (1,4) -> read_part=1, swap_pulse high 1 cycle, the next frame's first address is 8.
- Run 256 frames with FRAME_CNT_WIDTH=8 -> frame_count wraps 255->0 and read_part toggles each frame.
- night_target=3, FADE_FRAMES=2 -> night_rate 0,1,2,3 after swaps 2,4,6, then holds; target changed to 1 -> steps down 3->2->1.
- Assert rst at y=2 x=5 for 1 cycle -> next cycle read_x=0, read_addr=0, read_part=0, night_rate=0, data_enable=0 for 3 cycles.
- HSPP=0, VSPP=0 -> sync levels inverted, same cycles as above.
